// File: rtl/flash_qspi_arbiter.sv
// Two-port round-robin burst arbiter in front of a QSPI flash read controller.
// Reuses the device's continuous-read stream when a burst starts where the previous one ended.
module flash_qspi_arbiter #(
  parameter int LENGTH_WIDTH = 4
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic                    a_req,
  input  logic [23:0]             a_address,
  input  logic [LENGTH_WIDTH-1:0] a_length,
  output logic                    a_grant,
  output logic [31:0]             a_data,
  output logic                    a_dataValid,
  output logic                    a_done,
  input  logic                    b_req,
  input  logic [23:0]             b_address,
  input  logic [LENGTH_WIDTH-1:0] b_length,
  output logic                    b_grant,
  output logic [31:0]             b_data,
  output logic                    b_dataValid,
  output logic                    b_done,
  output logic                    qspi_enable,
  output logic [23:0]             qspi_address,
  output logic                    qspi_changeAddress,
  output logic                    qspi_requestData,
  input  logic [31:0]             qspi_readData,
  input  logic                    qspi_readDataValid,
  input  logic                    qspi_initialised,
  input  logic                    qspi_busy
);

  typedef enum logic [2:0] {WAIT_INIT, IDLE, CHANGE_ADDR, REQUEST, WAIT_DATA} state_t;

  state_t                  state_q, state_d;
  logic [23:0]             next_addr_q, next_addr_d;
  logic                    next_valid_q, next_valid_d;
  logic                    last_owner_q, last_owner_d;   // 0 = A, 1 = B
  logic [LENGTH_WIDTH-1:0] word_count_q, word_count_d;
  logic                    owner_q, owner_d;
  logic [23:0]             addr_q, addr_d;
  logic                    init_lost_q, init_lost_d;
  logic                    a_grant_q, a_grant_d, b_grant_q, b_grant_d;
  logic [31:0]             a_data_q, a_data_d, b_data_q, b_data_d;
  logic                    a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic                    a_done_q, a_done_d, b_done_q, b_done_d;
  logic                    enable_q;

  logic                    a_req_eff, b_req_eff, win_b, owner_req;
  logic                    chg_pulse, req_pulse;

  // A requester sees done in the same cycle we are back in IDLE; its req is
  // still high for that one edge, so keep it from immediately re-winning.
  assign a_req_eff = a_req && !a_done_q;
  assign b_req_eff = b_req && !b_done_q;
  assign win_b     = b_req_eff && (!a_req_eff || !last_owner_q);
  assign owner_req = owner_q ? b_req : a_req;

  always_comb begin
    state_d      = state_q;
    next_addr_d  = next_addr_q;
    next_valid_d = next_valid_q;
    last_owner_d = last_owner_q;
    word_count_d = word_count_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    init_lost_d  = init_lost_q;
    a_grant_d    = a_grant_q;
    b_grant_d    = b_grant_q;
    a_data_d     = a_data_q;
    b_data_d     = b_data_q;
    a_valid_d    = 1'b0;
    b_valid_d    = 1'b0;
    a_done_d     = 1'b0;
    b_done_d     = 1'b0;
    chg_pulse    = 1'b0;
    req_pulse    = 1'b0;

    case (state_q)
      WAIT_INIT: begin
        if (qspi_initialised) state_d = IDLE;
      end

      IDLE: begin
        if (!qspi_initialised) begin
          state_d = WAIT_INIT;
        end else if (a_req_eff || b_req_eff) begin
          owner_d      = win_b;
          last_owner_d = win_b;
          addr_d       = (win_b ? b_address : a_address) & 24'hFF_FFFC;
          word_count_d = win_b ? b_length : a_length;
          a_grant_d    = !win_b;
          b_grant_d    = win_b;
          init_lost_d  = 1'b0;
          state_d      = (next_valid_q && addr_d == next_addr_q) ? REQUEST : CHANGE_ADDR;
        end
      end

      CHANGE_ADDR, REQUEST: begin
        // No word is in flight here, so an abort can take effect at once.
        if (!qspi_initialised) begin
          a_grant_d    = 1'b0;
          b_grant_d    = 1'b0;
          next_valid_d = 1'b0;
          state_d      = WAIT_INIT;
        end else if (!owner_req) begin
          a_grant_d = 1'b0;
          b_grant_d = 1'b0;
          state_d   = IDLE;
        end else if (!qspi_busy) begin
          chg_pulse = (state_q == CHANGE_ADDR);
          req_pulse = (state_q == REQUEST);
          state_d   = (state_q == CHANGE_ADDR) ? REQUEST : WAIT_DATA;
        end
      end

      WAIT_DATA: begin
        if (!qspi_initialised) init_lost_d = 1'b1;
        if (qspi_readDataValid) begin
          next_addr_d  = addr_q + 24'd4;
          next_valid_d = 1'b1;
          addr_d       = addr_q + 24'd4;
          if (init_lost_q || !qspi_initialised) begin
            a_grant_d    = 1'b0;
            b_grant_d    = 1'b0;
            next_valid_d = 1'b0;
            state_d      = WAIT_INIT;
          end else if (!owner_req) begin
            a_grant_d = 1'b0;
            b_grant_d = 1'b0;
            state_d   = IDLE;
          end else begin
            if (owner_q) begin
              b_data_d  = qspi_readData;
              b_valid_d = 1'b1;
            end else begin
              a_data_d  = qspi_readData;
              a_valid_d = 1'b1;
            end
            if (word_count_q == '0) begin
              a_done_d  = !owner_q;
              b_done_d  = owner_q;
              a_grant_d = 1'b0;
              b_grant_d = 1'b0;
              state_d   = IDLE;
            end else begin
              word_count_d = word_count_q - 1'b1;
              state_d      = REQUEST;
            end
          end
        end
      end

      default: state_d = WAIT_INIT;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= WAIT_INIT;
      next_addr_q  <= '0;
      next_valid_q <= 1'b0;
      last_owner_q <= 1'b1;
      word_count_q <= '0;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      init_lost_q  <= 1'b0;
      a_grant_q    <= 1'b0;
      b_grant_q    <= 1'b0;
      a_data_q     <= '0;
      b_data_q     <= '0;
      a_valid_q    <= 1'b0;
      b_valid_q    <= 1'b0;
      a_done_q     <= 1'b0;
      b_done_q     <= 1'b0;
      enable_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_addr_q  <= next_addr_d;
      next_valid_q <= next_valid_d;
      last_owner_q <= last_owner_d;
      word_count_q <= word_count_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      init_lost_q  <= init_lost_d;
      a_grant_q    <= a_grant_d;
      b_grant_q    <= b_grant_d;
      a_data_q     <= a_data_d;
      b_data_q     <= b_data_d;
      a_valid_q    <= a_valid_d;
      b_valid_q    <= b_valid_d;
      a_done_q     <= a_done_d;
      b_done_q     <= b_done_d;
      enable_q     <= 1'b1;
    end
  end

  assign a_grant            = a_grant_q;
  assign a_data             = a_data_q;
  assign a_dataValid        = a_valid_q;
  assign a_done             = a_done_q;
  assign b_grant            = b_grant_q;
  assign b_data             = b_data_q;
  assign b_dataValid        = b_valid_q;
  assign b_done             = b_done_q;
  assign qspi_enable        = enable_q;
  assign qspi_address       = addr_q;
  assign qspi_changeAddress = chg_pulse;
  assign qspi_requestData   = req_pulse;

endmodule

// File: tb/tb_flash_qspi_arbiter.sv
// Directed bench for flash_qspi_arbiter with a small QSPI device model
// (two-cycle read latency, address-derived data) and a protocol monitor.
module tb_flash_qspi_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, b_req = 1'b0;
  logic [23:0] a_address = '0, b_address = '0;
  logic [3:0]  a_length = '0, b_length = '0;
  logic        a_grant, a_dataValid, a_done, b_grant, b_dataValid, b_done;
  logic [31:0] a_data, b_data;
  logic        qspi_enable, qspi_changeAddress, qspi_requestData;
  logic [23:0] qspi_address;
  logic [31:0] qspi_readData = '0;
  logic        qspi_readDataValid = 1'b0;
  logic        qspi_initialised = 1'b0;
  logic        qspi_busy = 1'b0;

  always #5 clk = ~clk;

  flash_qspi_arbiter #(.LENGTH_WIDTH(4)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .a_req(a_req), .a_address(a_address), .a_length(a_length),
    .a_grant(a_grant), .a_data(a_data), .a_dataValid(a_dataValid), .a_done(a_done),
    .b_req(b_req), .b_address(b_address), .b_length(b_length),
    .b_grant(b_grant), .b_data(b_data), .b_dataValid(b_dataValid), .b_done(b_done),
    .qspi_enable(qspi_enable), .qspi_address(qspi_address),
    .qspi_changeAddress(qspi_changeAddress), .qspi_requestData(qspi_requestData),
    .qspi_readData(qspi_readData), .qspi_readDataValid(qspi_readDataValid),
    .qspi_initialised(qspi_initialised), .qspi_busy(qspi_busy)
  );

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Device contents: a few hand-picked words, everything else tagged with its address.
  function automatic logic [31:0] dev_word(input logic [23:0] addr);
    if (addr == 24'h001000) return 32'h11;
    if (addr == 24'h001004) return 32'h22;
    if (addr == 24'h001008) return 32'h33;
    if (addr == 24'h00100C) return 32'h44;
    return {8'hD0, addr};
  endfunction

  // Device model and monitor (sample and drive at negedge).
  int          pend = 0;
  logic [31:0] pend_dat = '0;
  logic [23:0] maddr = '0;
  int          n_chg = 0, n_req = 0, viol = 0, a_dones = 0, b_dones = 0;
  logic [23:0] last_chg = '0;
  logic [31:0] a_done_dat = '0;
  logic        chg_prev = 1'b0, req_prev = 1'b0, ag_prev = 1'b0, bg_prev = 1'b0;
  logic [31:0] a_words[$];
  logic [31:0] b_words[$];
  bit          glog[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 0;
      qspi_readDataValid = 1'b0;
    end else begin
      qspi_readDataValid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          qspi_readDataValid = 1'b1;
          qspi_readData = pend_dat;
        end
      end
      if (qspi_changeAddress) begin
        n_chg++;
        last_chg = qspi_address;
        maddr = qspi_address;
      end
      if (qspi_requestData) begin
        n_req++;
        pend = 2;
        pend_dat = dev_word(maddr);
        maddr = maddr + 24'd4;
      end
      if ((qspi_changeAddress || qspi_requestData) && qspi_busy) viol++;
      if (qspi_changeAddress && qspi_requestData) viol++;
      if ((qspi_changeAddress && chg_prev) || (qspi_requestData && req_prev)) viol++;
      if ((a_grant && b_grant) || (a_dataValid && b_grant) || (b_dataValid && a_grant)) viol++;
      if (a_dataValid) a_words.push_back(a_data);
      if (b_dataValid) b_words.push_back(b_data);
      if (a_done) begin a_dones++; a_done_dat = a_data; end
      if (b_done) b_dones++;
      if (a_grant && !ag_prev) glog.push_back(1'b0);
      if (b_grant && !bg_prev) glog.push_back(1'b1);
    end
    chg_prev = qspi_changeAddress;
    req_prev = qspi_requestData;
    ag_prev  = a_grant;
    bg_prev  = b_grant;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit port, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((!port && a_done) || (port && b_done)) begin ok = 1'b1; break; end
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic burst(input bit port, input logic [23:0] addr, input logic [3:0] len, input string tag);
    tick(1);
    if (!port) begin a_req = 1'b1; a_address = addr; a_length = len; end
    else       begin b_req = 1'b1; b_address = addr; b_length = len; end
    wait_done(port, tag);
    tick(1);
    if (!port) a_req = 1'b0; else b_req = 1'b0;
  endtask

  int bc, br, bw, bd, bg;

  initial begin
    // Reset values
    @(negedge clk);
    chk("rst_enable", {31'd0, qspi_enable}, 32'd0);
    chk("rst_grant", {30'd0, a_grant, b_grant}, 32'd0);
    chk("rst_addr", {8'd0, qspi_address}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    a_req = 1'b1; a_address = 24'h000102; a_length = 4'd0;
    @(negedge clk);
    chk("enable_before_edge", {31'd0, qspi_enable}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("enable_after_edge", {31'd0, qspi_enable}, 32'd1);

    // No grants while flash not initialised
    tick(20);
    chk("noinit_grants", glog.size(), 0);
    chk("noinit_pulses", n_chg + n_req, 0);
    qspi_initialised = 1'b1;
    wait_done(1'b0, "first_done");
    tick(1);
    a_req = 1'b0;
    chk("first_chg_addr", {8'd0, last_chg}, 32'h000100);
    chk("first_chg_cnt", n_chg, 1);
    chk("first_word", a_done_dat, 32'hD000_0100);

    // Four-word A burst
    bc = n_chg; br = n_req; bw = a_words.size();
    burst(1'b0, 24'h001000, 4'd3, "a4_done");
    chk("a4_chg", n_chg - bc, 1);
    chk("a4_req", n_req - br, 4);
    chk("a4_words", a_words.size() - bw, 4);
    chk("a4_w0", a_words[bw], 32'h11);
    chk("a4_w1", a_words[bw+1], 32'h22);
    chk("a4_w2", a_words[bw+2], 32'h33);
    chk("a4_done_dat", a_done_dat, 32'h44);
    chk("a4_grant_low", {31'd0, a_grant}, 32'd0);

    // Continuous reuse, then a jump
    bc = n_chg; bw = b_words.size();
    burst(1'b1, 24'h001010, 4'd0, "b_cont_done");
    chk("b_cont_chg", n_chg - bc, 0);
    chk("b_cont_word", b_words[bw], 32'hD000_1010);
    bc = n_chg;
    burst(1'b1, 24'h002000, 4'd0, "b_jump_done");
    chk("b_jump_chg", n_chg - bc, 1);
    chk("b_jump_addr", {8'd0, last_chg}, 32'h002000);
    chk("b_jump_word", b_data, 32'hD000_2000);

    // Simultaneous requests, twice
    for (int k = 0; k < 2; k++) begin
      bg = glog.size();
      tick(1);
      a_req = 1'b1; a_address = 24'h003000; a_length = 4'd0;
      b_req = 1'b1; b_address = 24'h004000; b_length = 4'd0;
      wait_done(1'b0, "tie_a_done");
      tick(1); a_req = 1'b0;
      wait_done(1'b1, "tie_b_done");
      tick(1); b_req = 1'b0;
      chk("tie_first_is_a", {31'd0, glog[bg]}, 32'd0);
      chk("tie_second_is_b", {31'd0, glog[bg+1]}, 32'd1);
    end

    // Both held continuously: A, B, A
    bg = glog.size();
    tick(1);
    a_req = 1'b1; b_req = 1'b1;
    wait_done(1'b0, "rr_a1");
    wait_done(1'b1, "rr_b1");
    wait_done(1'b0, "rr_a2");
    tick(1);
    a_req = 1'b0; b_req = 1'b0;
    tick(30);
    chk("rr_g0", {31'd0, glog[bg]}, 32'd0);
    chk("rr_g1", {31'd0, glog[bg+1]}, 32'd1);
    chk("rr_g2", {31'd0, glog[bg+2]}, 32'd0);
    chk("rr_idle", {30'd0, a_grant, b_grant}, 32'd0);

    // Busy stalls in CHANGE_ADDR and REQUEST
    bc = n_chg; br = n_req;
    qspi_busy = 1'b1;
    a_req = 1'b1; a_address = 24'h005000; a_length = 4'd0;
    tick(6);
    chk("busy_no_chg", n_chg - bc, 0);
    qspi_busy = 1'b0;
    tick(1);
    qspi_busy = 1'b1;
    tick(5);
    chk("busy_one_chg", n_chg - bc, 1);
    chk("busy_no_req", n_req - br, 0);
    qspi_busy = 1'b0;
    wait_done(1'b0, "busy_done");
    tick(1); a_req = 1'b0;
    chk("busy_one_req", n_req - br, 1);
    chk("busy_word", a_done_dat, 32'hD000_5000);

    // Address wrap keeps continuity
    bc = n_chg; br = n_req; bw = a_words.size();
    burst(1'b0, 24'hFFFFFC, 4'd1, "wrap_done");
    chk("wrap_chg", n_chg - bc, 1);
    chk("wrap_req", n_req - br, 2);
    chk("wrap_w0", a_words[bw], 32'hD0FF_FFFC);
    chk("wrap_w1", a_words[bw+1], 32'hD000_0000);
    bc = n_chg;
    burst(1'b1, 24'h000004, 4'd0, "wrap_next_done");
    chk("wrap_next_chg", n_chg - bc, 0);
    chk("wrap_next_word", b_data, 32'hD000_0004);

    // Owner drops req mid-burst
    bc = n_chg; bw = a_words.size(); bd = a_dones;
    tick(1);
    a_req = 1'b1; a_address = 24'h000008; a_length = 4'd3;
    for (int i = 0; i < 200 && a_words.size() < bw + 2; i++) @(negedge clk);
    tick(1);
    a_req = 1'b0;
    tick(20);
    chk("drop_words", a_words.size() - bw, 2);
    chk("drop_no_done", a_dones - bd, 0);
    chk("drop_grant", {31'd0, a_grant}, 32'd0);
    chk("drop_cont_chg", n_chg - bc, 0);
    bc = n_chg;
    burst(1'b1, 24'h000014, 4'd0, "drop_next_done");
    chk("drop_next_chg", n_chg - bc, 0);
    chk("drop_next_word", b_data, 32'hD000_0014);

    // Flash loses initialisation mid-burst
    bw = a_words.size(); bd = a_dones;
    tick(1);
    a_req = 1'b1; a_address = 24'h006000; a_length = 4'd3;
    for (int i = 0; i < 200 && a_words.size() < bw + 1; i++) @(negedge clk);
    tick(1);
    qspi_initialised = 1'b0; a_req = 1'b0;
    tick(10);
    chk("init_words", a_words.size() - bw, 1);
    chk("init_no_done", a_dones - bd, 0);
    chk("init_grant", {31'd0, a_grant}, 32'd0);
    qspi_initialised = 1'b1;
    tick(2);
    bc = n_chg;
    burst(1'b0, 24'h006008, 4'd0, "reinit_done");
    chk("reinit_chg", n_chg - bc, 1);
    chk("reinit_word", a_done_dat, 32'hD000_6008);
    chk("protocol_viol", viol, 0);

    // Asynchronous reset mid-burst
    tick(1);
    a_req = 1'b1; a_address = 24'h007000; a_length = 4'd3;
    tick(4);
    chk("pre_rst_grant", {31'd0, a_grant}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_grant", {31'd0, a_grant}, 32'd0);
    chk("arst_enable", {31'd0, qspi_enable}, 32'd0);
    chk("arst_addr", {8'd0, qspi_address}, 32'd0);
    a_req = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
    $fatal(1);
  end

endmodule

// File: doc/flash_qspi_arbiter.md
Name: flash_qspi_arbiter

Overview:
- Shares one QSPI flash read controller between two burst-read requesters: port A (flash cache fill) and port B (boot loader / DMA).
- Sits between the requesters and the QSPI device interface.
- Sequences address changes, per-word data requests and continuous-read reuse.
- Grants whole bursts with round-robin arbitration.

Parameters:
- LENGTH_WIDTH, 4, width of the burst length field; a burst is req_length+1 words, 1..2^LENGTH_WIDTH.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_ni  in  1  asynchronous active-low reset
- a_req  in  1  port A burst request; level, held until a_done
- a_address  in  24  port A byte start address; bits [1:0] ignored
- a_length  in  LENGTH_WIDTH  port A words minus one
- a_grant  out  1  port A owns the controller
- a_data  out  32  read word for port A
- a_dataValid  out  1  one-cycle strobe, a_data valid
- a_done  out  1  one-cycle pulse with the final word
- b_req, b_address, b_length, b_grant, b_data, b_dataValid, b_done: same as port A, for port B
- qspi_enable  out  1  controller enable
- qspi_address  out  24  word-aligned read address
- qspi_changeAddress  out  1  one-cycle pulse, start a new continuous read at qspi_address
- qspi_requestData  out  1  one-cycle pulse, fetch the next 32-bit word
- qspi_readData  in  32  returned word
- qspi_readDataValid  in  1  strobe, qspi_readData valid
- qspi_initialised  in  1  flash has left startup
- qspi_busy  in  1  controller cannot accept a pulse this cycle

Behaviour:
- Reset: every output is 0. Internal registers clear to: state WAIT_INIT, nextAddr 0, nextValid 0, lastOwner B, wordCount 0.
- qspi_enable: registered; goes to 1 on the first clock edge after reset deasserts and stays 1.
- States: WAIT_INIT, IDLE, CHANGE_ADDR, REQUEST, WAIT_DATA.
- WAIT_INIT -> IDLE when qspi_initialised=1. No grants are issued before then.
- IDLE arbitration:
  - Only one requester: it wins.
  - Both requesting: the port other than lastOwner wins (round-robin), so A wins the first tie after reset.
  - On a win: latch owner, burst address {addr[23:2],2'b00} and length into wordCount. Set owner grant=1 on the next cycle; lastOwner is updated.
  - If nextValid=1 and the latched address equals nextAddr, go to REQUEST (continuous read reused). Otherwise go to CHANGE_ADDR.
- CHANGE_ADDR: drive qspi_address. Pulse qspi_changeAddress for exactly one cycle in the first cycle with qspi_busy=0, then go to REQUEST.
- REQUEST: pulse qspi_requestData for one cycle when qspi_busy=0, then go to WAIT_DATA.
- WAIT_DATA, on qspi_readDataValid:
  - Register qspi_readData onto the owner's data output and pulse the owner's dataValid on the next cycle.
  - nextAddr <= current address + 4, wrapping mod 2^24 (0xFFFFFC -> 0x000000, continuity kept); nextValid <= 1.
  - If wordCount==0: pulse owner done together with dataValid, drop grant in the same cycle, go to IDLE. Otherwise decrement wordCount and go to REQUEST.
- The non-owner's grant, dataValid and done stay 0 throughout the burst. Its req is ignored until IDLE.
- Owner drops req mid-burst: the in-flight word completes and is discarded (no dataValid, no done). Grant drops, state returns to IDLE, and nextAddr/nextValid update as normal.
- Owner req changes of address/length mid-burst are ignored; values are latched at grant.
- Port A and port B data outputs hold their last value between strobes.
- qspi_initialised falls while not in WAIT_INIT:
  - The current word's readDataValid is still awaited.
  - After it, the burst aborts: grant drops, no done, nextValid <= 0, state goes to WAIT_INIT.
  - Exception: an idle arbiter moves to WAIT_INIT immediately.
- At most one qspi pulse (changeAddress or requestData) is asserted per cycle, and never while qspi_busy=1.
- A readDataValid outside WAIT_DATA is ignored.
- Asynchronous reset mid-burst returns everything to reset values immediately. nextValid=0 forces a changeAddress on the next burst.

Test Plan:
- Reset released, qspi_initialised held 0 for 20 cycles with a_req=1 -> no grant, no qspi pulses. Raise initialised -> a_grant, then changeAddress with qspi_address=0x000100 (a_address=0x000102).
- A burst: a_address=0x001000, a_length=3, device returns 0x11,0x22,0x33,0x44 -> 1 changeAddress, 4 requestData, 4 a_dataValid in order, a_done with 0x44, a_grant low after.
- Follow-up B burst at 0x001010, length 0 -> no changeAddress (continuous). B burst at 0x002000 -> changeAddress issued.
- a_req and b_req rise in the same cycle, twice in succession -> A served first, then B. With both held continuously, grants alternate A,B,A.
- qspi_busy held 1 for 5 cycles in CHANGE_ADDR and REQUEST -> pulses delayed until busy=0, each exactly one cycle long.
- Burst at 0xFFFFFC, length 1 -> second word read without changeAddress. nextAddr=0x000004. Owner drops req mid-burst -> no done, returns to IDLE.
